// File: rtl/xres_reset_seq_pkg.sv
// Shared types and default parameters for the XRES reset sequencer.
package xres_reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_CLK = 2'd1,
    CORE     = 2'd2,
    RUN      = 2'd3
  } seq_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 16;
  localparam int DEF_STAGE_GAP     = 8;
  localparam int DEF_GLITCH_CNT_W  = 8;

endpackage

// File: rtl/xres_sync_filter.sv
// Pad XRES synchronizer and cycle-count debounce filter.
// The rejected-glitch counter is present only with XRES_RESET_SEQ_GLITCH_MON_EN.
module xres_sync_filter
  import xres_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
`ifdef XRES_RESET_SEQ_GLITCH_MON_EN
  ,
  parameter int GLITCH_CNT_W  = DEF_GLITCH_CNT_W
`endif
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    xres_h_n,
  output logic                    xres_filt
`ifdef XRES_RESET_SEQ_GLITCH_MON_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   xs;

  assign xs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], xres_h_n};
    filt_d = filt_q;
    cnt_d  = '0;
    // Counter only advances while the sample disagrees; it toggles before it could wrap.
    if (xs != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = xs;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign xres_filt = filt_q;

`ifdef XRES_RESET_SEQ_GLITCH_MON_EN
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

  always_comb begin
    glitch_d = glitch_q;
    if ((xs == filt_q) && (cnt_q != '0) && (glitch_q != '1)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: rtl/xres_reset_seq.sv
// XRES pad consumer: debounced pad level drives an ordered core/peripheral reset release.
// Optional glitch monitor enabled by XRES_RESET_SEQ_GLITCH_MON_EN.
//
// state    | meaning
// HOLD     | both domains held in reset
// WAIT_CLK | pad released, waiting for clk_ok
// CORE     | core released, counting gap to peripheral release
// RUN      | both domains released
module xres_reset_seq
  import xres_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int STAGE_GAP     = DEF_STAGE_GAP
`ifdef XRES_RESET_SEQ_GLITCH_MON_EN
  ,
  parameter int GLITCH_CNT_W  = DEF_GLITCH_CNT_W
`endif
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    xres_h_n,
  input  logic                    clk_ok,
  output logic                    xres_filt,
  output logic                    core_resetb,
  output logic                    periph_resetb,
  output logic [1:0]              seq_state
`ifdef XRES_RESET_SEQ_GLITCH_MON_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(STAGE_GAP - 1);

  seq_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             core_resetb_q, core_resetb_d;
  logic             periph_resetb_q, periph_resetb_d;

  xres_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
`ifdef XRES_RESET_SEQ_GLITCH_MON_EN
    ,
    .GLITCH_CNT_W  (GLITCH_CNT_W)
`endif
  ) u_sync_filter (
    .clk        (clk),
    .resetb     (resetb),
    .xres_h_n   (xres_h_n),
    .xres_filt  (xres_filt)
`ifdef XRES_RESET_SEQ_GLITCH_MON_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q         <= HOLD;
      gap_q           <= '0;
      core_resetb_q   <= 1'b0;
      periph_resetb_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      gap_q           <= gap_d;
      core_resetb_q   <= core_resetb_d;
      periph_resetb_q <= periph_resetb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (!xres_filt) begin
      state_d = HOLD;
    end else if (!clk_ok && ((state_q == CORE) || (state_q == RUN))) begin
      state_d = HOLD;
    end else begin
      unique case (state_q)
        HOLD:     state_d = WAIT_CLK;
        WAIT_CLK: begin
          if (clk_ok) begin
            state_d = CORE;
            gap_d   = '0;
          end
        end
        CORE: begin
          if (gap_q == GAP_MAX) begin
            state_d = RUN;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN:      state_d = RUN;
        default:  state_d = HOLD;
      endcase
    end
  end

  // Registered from the next state so outputs change on the same edge as the state.
  always_comb begin
    core_resetb_d   = (state_d == CORE) || (state_d == RUN);
    periph_resetb_d = (state_d == RUN);
  end

  assign core_resetb   = core_resetb_q;
  assign periph_resetb = periph_resetb_q;
  assign seq_state     = state_q;

endmodule
